// File: rtl/sevenseg_msg_seq.sv
// sevenseg_msg_seq: steps a four-digit seven-segment display through four
// fixed words (SCoC, TEST, 2017, GAPH), with a blank gap between words.
// Words advance on a hold timer or on debounced next/prev buttons, and the
// pause switch freezes the hold timer. All outputs are registered.
module sevenseg_msg_seq #(
  parameter int HOLD_CYCLES  = 100_000_000,
  parameter int BLANK_CYCLES = 10_000_000,
  parameter int DB_CYCLES    = 1_000_000,
  parameter int CNT_W        = 27,
  parameter int DB_W         = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       pause,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [1:0] decplace,
  output logic [1:0] msg_idx,
  output logic       msg_changed
);

  typedef enum logic {SHOW, BLANK} state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_CYCLES - 1);
  localparam logic [15:0]      BLANK_WORD = 16'hFFFF;

  // Word table, packed as {digit0, digit1, digit2, digit3}.
  function automatic logic [15:0] wordFor(input logic [1:0] idx);
    logic [15:0] w;
    w = 16'h1023;
    case (idx)
      2'd0:    w = 16'h1023;
      2'd1:    w = 16'hCDEC;
      2'd2:    w = 16'h4567;
      2'd3:    w = 16'h89AB;
      default: w = 16'h1023;
    endcase
    return w;
  endfunction

  // Input conditioning state. Bit 0 is next, bit 1 is prev, bit 2 is pause.
  logic [2:0]            meta_q, sync_q;
  logic [1:0]            acc_q, acc_d;
  logic [1:0][DB_W-1:0]  dbCnt_q, dbCnt_d;
  logic [1:0]            pulse_q, pulse_d;

  // Sequencer state.
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      timer_q, timer_d;
  logic [1:0]            idx_q, idx_d;
  logic [15:0]           digits_q, digits_d;
  logic [1:0]            decplace_q;
  logic                  changed_q, changed_d;

  logic                  nxtGo, prvGo, paused;

  // Two-flop synchronizer for the raw buttons and the pause switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {pause, btn_prev, btn_next};
      sync_q <= meta_q;
    end
  end

  // Debounce each button and produce a one-cycle pulse on an accepted rising level.
  always_comb begin
    acc_d   = acc_q;
    dbCnt_d = '0;
    pulse_d = '0;
    for (int b = 0; b < 2; b++) begin
      if (sync_q[b] != acc_q[b]) begin
        if (dbCnt_q[b] == DB_LAST) begin
          acc_d[b]   = sync_q[b];
          pulse_d[b] = sync_q[b];
        end else begin
          dbCnt_d[b] = dbCnt_q[b] + DB_W'(1);
        end
      end
    end
  end

  // Debounce registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      dbCnt_q <= '0;
      pulse_q <= '0;
    end else begin
      acc_q   <= acc_d;
      dbCnt_q <= dbCnt_d;
      pulse_q <= pulse_d;
    end
  end

  // A next and a prev pulse landing together cancel each other out.
  assign nxtGo  = pulse_q[0] & ~pulse_q[1];
  assign prvGo  = pulse_q[1] & ~pulse_q[0];
  assign paused = sync_q[2];

  // Next-state logic: word selection, hold/blank timing and the reveal pulse.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    digits_d  = digits_q;
    changed_d = 1'b0;
    case (state_q)
      SHOW: begin
        if (nxtGo || prvGo) begin
          state_d  = BLANK;
          idx_d    = nxtGo ? idx_q + 2'd1 : idx_q - 2'd1;
          timer_d  = '0;
          digits_d = BLANK_WORD;
        end else if (!paused) begin
          if (timer_q == HOLD_LAST) begin
            state_d  = BLANK;
            idx_d    = idx_q + 2'd1;
            timer_d  = '0;
            digits_d = BLANK_WORD;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
      end
      BLANK: begin
        if (nxtGo) begin
          idx_d = idx_q + 2'd1;
        end else if (prvGo) begin
          idx_d = idx_q - 2'd1;
        end
        if (timer_q == BLANK_LAST) begin
          state_d   = SHOW;
          timer_d   = '0;
          digits_d  = wordFor(idx_d);
          changed_d = 1'b1;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = SHOW;
      end
    endcase
  end

  // Sequencer registers; the dp marker tracks the target word index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SHOW;
      timer_q    <= '0;
      idx_q      <= 2'd0;
      digits_q   <= 16'h1023;
      decplace_q <= 2'b11;
      changed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      digits_q   <= digits_d;
      decplace_q <= ~idx_d;
      changed_q  <= changed_d;
    end
  end

  assign digit0      = digits_q[15:12];
  assign digit1      = digits_q[11:8];
  assign digit2      = digits_q[7:4];
  assign digit3      = digits_q[3:0];
  assign decplace    = decplace_q;
  assign msg_idx     = idx_q;
  assign msg_changed = changed_q;

endmodule

// File: tb/tb_sevenseg_msg_seq.sv
// tb_sevenseg_msg_seq: directed bench for the message sequencer with short
// hold/blank/debounce times, a table-driven auto-run and hand-written corner cases.
module tb_sevenseg_msg_seq;

  localparam int HOLD  = 8;
  localparam int BLANK = 2;
  localparam int DB    = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_next, btn_prev, pause;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [1:0] decplace, msg_idx;
  logic       msg_changed;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  typedef struct {
    logic        bn;
    logic        bp;
    logic        ps;
    logic [15:0] expDigits;
    logic [1:0]  expIdx;
    logic        expChg;
  } vec_t;

  vec_t        vecs [50];
  logic [15:0] words [4];

  sevenseg_msg_seq #(
    .HOLD_CYCLES (HOLD),
    .BLANK_CYCLES(BLANK),
    .DB_CYCLES   (DB),
    .CNT_W       (4),
    .DB_W        (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_next   (btn_next),
    .btn_prev   (btn_prev),
    .pause      (pause),
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .decplace   (decplace),
    .msg_idx    (msg_idx),
    .msg_changed(msg_changed)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven 1 unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic gotoCycle(input int target);
    while (cyc < target) tick();
  endtask

  task automatic applyStimulus(input logic bn, input logic bp, input logic ps);
    btn_next = bn;
    btn_prev = bp;
    pause    = ps;
  endtask

  // Compare all outputs right now; decplace must always be the inverted index.
  task automatic checkNow(input string name, input logic [15:0] expD,
                          input logic [1:0] expI, input logic expC);
    logic [15:0] act;
    logic [1:0]  expDec;
    act    = {digit0, digit1, digit2, digit3};
    expDec = ~expI;
    total++;
    if (act === expD && msg_idx === expI && decplace === expDec && msg_changed === expC)
      passed++;
    else
      $display("[TB] FAIL %s cyc=%0d: got digits=%h idx=%0d dec=%b chg=%b, want digits=%h idx=%0d dec=%b chg=%b",
               name, cyc, act, msg_idx, decplace, msg_changed, expD, expI, expDec, expC);
  endtask

  // Compare on the falling edge, away from the active edge.
  task automatic checkOutput(input string name, input logic [15:0] expD,
                             input logic [1:0] expI, input logic expC);
    @(negedge clk);
    checkNow(name, expD, expI, expC);
  endtask

  // Hold reset for two edges and release just after a rising edge (cycle 0).
  task automatic resetPulse();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    int p;
    int w;
    words = '{16'h1023, 16'hCDEC, 16'h4567, 16'h89AB};

    // Auto-run schedule: 8 cycles SHOW then 2 cycles BLANK showing the next index.
    for (int n = 0; n < 50; n++) begin
      p = n % 10;
      w = (n / 10) % 4;
      vecs[n].bn = 1'b0;
      vecs[n].bp = 1'b0;
      vecs[n].ps = 1'b0;
      if (p < 8) begin
        vecs[n].expDigits = words[w];
        vecs[n].expIdx    = 2'(w);
        vecs[n].expChg    = (p == 0 && n > 0);
      end else begin
        vecs[n].expDigits = 16'hFFFF;
        vecs[n].expIdx    = 2'((w + 1) % 4);
        vecs[n].expChg    = 1'b0;
      end
    end

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkNow("reset", 16'h1023, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;

    for (int n = 0; n < 50; n++) begin
      if (n > 0) tick();
      applyStimulus(vecs[n].bn, vecs[n].bp, vecs[n].ps);
      checkOutput($sformatf("auto%0d", n), vecs[n].expDigits, vecs[n].expIdx, vecs[n].expChg);
    end

    // Held prev button: exactly one pulse, acted on 6 edges after the press.
    resetPulse();
    applyStimulus(1'b0, 1'b1, 1'b0);
    gotoCycle(5);  checkOutput("prvWait",   16'h1023, 2'd0, 1'b0);
    gotoCycle(6);  checkOutput("prvBlank",  16'hFFFF, 2'd3, 1'b0);
    gotoCycle(8);  checkOutput("prvShow",   16'h89AB, 2'd3, 1'b1);
    gotoCycle(9);  checkOutput("prvChgEnd", 16'h89AB, 2'd3, 1'b0);
    gotoCycle(10); applyStimulus(1'b0, 1'b0, 1'b0);
    gotoCycle(15); checkOutput("prvOnce",   16'h89AB, 2'd3, 1'b0);
    gotoCycle(16); checkOutput("prvWrap",   16'hFFFF, 2'd0, 1'b0);

    // One-cycle glitches on next never get accepted.
    resetPulse();
    for (int k = 0; k < 6; k++) begin
      gotoCycle(k);
      applyStimulus(k % 2 == 0, 1'b0, 1'b0);
    end
    gotoCycle(6);  applyStimulus(1'b0, 1'b0, 1'b0);
    gotoCycle(7);  checkOutput("glitch",      16'h1023, 2'd0, 1'b0);
    gotoCycle(8);  checkOutput("glitchBlank", 16'hFFFF, 2'd1, 1'b0);

    // Pause during SHOW idx2: timer frozen at 2, then 5 more counts after release.
    resetPulse();
    gotoCycle(20); applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("pauseStart", 16'h4567, 2'd2, 1'b1);
    gotoCycle(40); checkOutput("pauseMid",  16'h4567, 2'd2, 1'b0);
    gotoCycle(69); checkOutput("pauseEnd",  16'h4567, 2'd2, 1'b0);
    gotoCycle(70); applyStimulus(1'b0, 1'b0, 1'b0);
    gotoCycle(77); checkOutput("resumeHold",  16'h4567, 2'd2, 1'b0);
    gotoCycle(78); checkOutput("resumeBlank", 16'hFFFF, 2'd3, 1'b0);

    // Next button still advances while paused; BLANK ignores pause.
    resetPulse();
    applyStimulus(1'b0, 1'b0, 1'b1);
    gotoCycle(3);  applyStimulus(1'b1, 1'b0, 1'b1);
    gotoCycle(8);  checkOutput("pausedHold",  16'h1023, 2'd0, 1'b0);
    gotoCycle(9);  checkOutput("pausedNext",  16'hFFFF, 2'd1, 1'b0);
    gotoCycle(11); checkOutput("pausedShow",  16'hCDEC, 2'd1, 1'b1);
    gotoCycle(12); applyStimulus(1'b0, 1'b0, 1'b1);
    gotoCycle(30); checkOutput("pausedStay",  16'hCDEC, 2'd1, 1'b0);

    // Next and prev together cancel.
    resetPulse();
    applyStimulus(1'b0, 1'b0, 1'b1);
    gotoCycle(3);  applyStimulus(1'b1, 1'b1, 1'b1);
    gotoCycle(9);  checkOutput("bothIgnored", 16'h1023, 2'd0, 1'b0);
    gotoCycle(12); applyStimulus(1'b0, 1'b0, 1'b1);
    gotoCycle(20); checkOutput("bothLater",   16'h1023, 2'd0, 1'b0);

    // Next pulse during the auto BLANK retargets without restarting the gap.
    resetPulse();
    gotoCycle(3);  applyStimulus(1'b1, 1'b0, 1'b0);
    gotoCycle(8);  checkOutput("skipBlank1", 16'hFFFF, 2'd1, 1'b0);
    gotoCycle(9);  checkOutput("skipBlank2", 16'hFFFF, 2'd2, 1'b0);
    gotoCycle(10); checkOutput("skipShow",   16'h4567, 2'd2, 1'b1);
    gotoCycle(11); applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("skipSettle", 16'h4567, 2'd2, 1'b0);

    // Button pulse beats the hold timer expiring in the same cycle.
    resetPulse();
    gotoCycle(2);  applyStimulus(1'b0, 1'b1, 1'b0);
    gotoCycle(7);  checkOutput("prioHold",  16'h1023, 2'd0, 1'b0);
    gotoCycle(8);  checkOutput("prioBlank", 16'hFFFF, 2'd3, 1'b0);
    gotoCycle(10); checkOutput("prioShow",  16'h89AB, 2'd3, 1'b1);
    gotoCycle(11); applyStimulus(1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of the gap before GAPH.
    resetPulse();
    gotoCycle(28); checkOutput("blankIdx3", 16'hFFFF, 2'd3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkNow("rstMidBlank", 16'h1023, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    checkOutput("postRst", 16'h1023, 2'd0, 1'b0);

    // Reset with a next pulse pending: nothing must survive.
    resetPulse();
    applyStimulus(1'b1, 1'b0, 1'b0);
    gotoCycle(5);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    gotoCycle(7);  checkOutput("noPendingPulse", 16'h1023, 2'd0, 1'b0);
    gotoCycle(8);  checkOutput("noPendingBlank", 16'hFFFF, 2'd1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
